// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (bi & ~(x ^ y));

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b - bin, LSB first through one cell.
// Optional zero/lt result flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             lt
`endif
);

  // State table
  //   IDLE | waiting for start; diff/bout hold the last result
  //   RUN  | one operand bit processed per edge, LSB first
  //   DONE | result valid, done pulses for this single cycle

  localparam int CW = $clog2(WIDTH);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q, busy_q, done_q;

  logic             cell_d, cell_bo, last_bit;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt_d;

  full_sub_cell u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign diff_d   = {cell_d, diff_q[WIDTH-1:1]};
  assign cnt_d    = cnt_q + CW'(1);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_FLAGS_EN
  logic zero_q, lt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_d;
          brw_q  <= cell_bo;
          // Counter parks on the last index instead of wrapping
          cnt_q  <= last_bit ? cnt_q : cnt_d;
          if (last_bit) begin
            bout_q  <= cell_bo;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q  <= (diff_d == '0);
            lt_q    <= cell_bo;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero = zero_q;
  assign lt   = lt_q;
`endif

endmodule
